// File: rtl/cam_lookup_arbiter.sv
// cam_lookup_arbiter: round-robin arbiter that shares one fixed-latency CAM
// lookup port between several search engines. Only one lookup is in flight
// at a time, and its result is returned to the requester that issued it.
// Optional statistics counters are enabled by defining CAM_ARB_STATS_EN.
// All outputs are registered, so req_rdy follows req_vld by one cycle.
// Arbitration also runs in RESP so that a back-to-back grant lands on the
// first IDLE cycle, giving one lookup every LAT+3 cycles.
module cam_lookup_arbiter #(
  parameter int NREQ  = 2,
  parameter int KEY_W = 32,
  parameter int RES_W = 16,
  parameter int LAT   = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_vld,
  input  logic [NREQ*KEY_W-1:0]   req_key,
  output logic [NREQ-1:0]         req_rdy,
  output logic [NREQ-1:0]         rsp_vld,
  output logic                    rsp_hit,
  output logic [RES_W-1:0]        rsp_data,
  output logic                    cam_en,
  output logic [KEY_W-1:0]        cam_key,
  input  logic                    cam_hit,
  input  logic [RES_W-1:0]        cam_data,
  output logic                    busy
`ifdef CAM_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]      grant_cnt,
  output logic [15:0]             hit_cnt
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);
  localparam logic [IW:0]   NREQ_W    = (IW+1)'(NREQ);
  localparam logic [3:0]    WAIT_LOAD = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    ptr, ptr_nxt, gnt_idx, base_idx, arb_idx;
  logic [IW:0]      pos;
  logic             arb_any, grant_now, sample_now;
  logic [3:0]       cnt, cnt_nxt;
  logic [KEY_W-1:0] key_arr [NREQ];
  logic [NREQ-1:0]  arb_onehot, gnt_onehot;

  // Unpack the flat key bus so the granted key can be selected by index.
  always_comb begin
    for (int i = 0; i < NREQ; i++) key_arr[i] = req_key[i*KEY_W +: KEY_W];
  end

  // Search origin: in RESP look ahead from the requester after the current grant.
  always_comb begin
    base_idx = ptr;
    if (state == RESP) base_idx = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
  end

  // Scan upward from the origin with wrap; the closest active requester wins.
  always_comb begin
    arb_any = 1'b0;
    arb_idx = '0;
    pos     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, base_idx} + (IW+1)'(k);
      if (pos >= NREQ_W) pos = pos - NREQ_W;
      if (req_vld[pos[IW-1:0]]) begin
        arb_any = 1'b1;
        arb_idx = pos[IW-1:0];
      end
    end
  end

  assign grant_now  = arb_any && (((state == IDLE) && (req_rdy == '0)) || (state == RESP));
  assign sample_now = (state == WAIT) && (cnt == '0);
  assign arb_onehot = NREQ'(1) << arb_idx;
  assign gnt_onehot = NREQ'(1) << gnt_idx;

  // Next-state logic for the lookup sequence, wait counter and rotation pointer.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    case (state)
      IDLE:  if (req_rdy != '0) state_nxt = ISSUE;
      ISSUE: begin
        state_nxt = WAIT;
        cnt_nxt   = WAIT_LOAD;
      end
      WAIT:  begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 4'd1;
      end
      RESP:  begin
        state_nxt = IDLE;
        ptr_nxt   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and pointer registers; reset discards any in-flight lookup.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Registered outputs: grant pulse, key latch, CAM strobe, response and busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_rdy  <= '0;
      gnt_idx  <= '0;
      cam_key  <= '0;
      cam_en   <= 1'b0;
      rsp_vld  <= '0;
      rsp_hit  <= 1'b0;
      rsp_data <= '0;
      busy     <= 1'b0;
    end else begin
      req_rdy <= grant_now ? arb_onehot : '0;
      if (grant_now) begin
        gnt_idx <= arb_idx;
        cam_key <= key_arr[arb_idx];
      end
      cam_en   <= (state == IDLE) && (req_rdy != '0);
      rsp_vld  <= sample_now ? gnt_onehot : '0;
      rsp_hit  <= sample_now && cam_hit;
      rsp_data <= (sample_now && cam_hit) ? cam_data : '0;
      busy     <= (state_nxt != IDLE);
    end
  end

`ifdef CAM_ARB_STATS_EN
  // Saturating per-requester grant counters and a response hit counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_cnt <= '0;
      hit_cnt   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_now && (arb_idx == IW'(i)) && (grant_cnt[i*16 +: 16] != 16'hFFFF))
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
      if (sample_now && cam_hit && (hit_cnt != 16'hFFFF))
        hit_cnt <= hit_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cam_lookup_arbiter.sv
// tb_cam_lookup_arbiter: directed bench for cam_lookup_arbiter with a CAM
// model, per-requester key queues and a response scoreboard.
// Statistics checks are compiled in when CAM_ARB_STATS_EN is defined.
module tb_cam_lookup_arbiter;

  localparam int NREQ  = 2;
  localparam int KEY_W = 32;
  localparam int RES_W = 16;
  localparam int LAT   = 2;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_vld;
  logic [NREQ*KEY_W-1:0] req_key;
  logic [NREQ-1:0]       req_rdy;
  logic [NREQ-1:0]       rsp_vld;
  logic                  rsp_hit;
  logic [RES_W-1:0]      rsp_data;
  logic                  cam_en;
  logic [KEY_W-1:0]      cam_key;
  logic                  cam_hit;
  logic [RES_W-1:0]      cam_data;
  logic                  busy;
`ifdef CAM_ARB_STATS_EN
  logic [NREQ*16-1:0]    grant_cnt;
  logic [15:0]           hit_cnt;
`endif

  cam_lookup_arbiter #(.NREQ(NREQ), .KEY_W(KEY_W), .RES_W(RES_W), .LAT(LAT)) dut (
    .clock    (clock),
    .reset    (reset),
    .req_vld  (req_vld),
    .req_key  (req_key),
    .req_rdy  (req_rdy),
    .rsp_vld  (rsp_vld),
    .rsp_hit  (rsp_hit),
    .rsp_data (rsp_data),
    .cam_en   (cam_en),
    .cam_key  (cam_key),
    .cam_hit  (cam_hit),
    .cam_data (cam_data),
    .busy     (busy)
`ifdef CAM_ARB_STATS_EN
    ,
    .grant_cnt(grant_cnt),
    .hit_cnt  (hit_cnt)
`endif
  );

  typedef struct {
    logic [1:0]  vld;
    logic        hit;
    logic [15:0] data;
    int          due;
  } rsp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  rsp_t        sb[$];
  rsp_t        ent;
  logic [31:0] kq0[$];
  logic [31:0] kq1[$];
  int          exp_gnt[$];
  logic        pulse1 = 1'b0;
  logic [31:0] pulse_key = '0;
  logic        pend = 1'b0;
  int          pend_due = 0;
  logic [31:0] pend_key = '0;
  logic        cam_exp_vld = 1'b0;
  int          cam_exp_cyc = 0;
  logic [31:0] cam_exp_key = '0;
  logic        spacing_en = 1'b0;
  logic        have_last = 1'b0;
  int          last_rdy = 0;
  int          mon_g;
  logic [31:0] mon_key;
  logic [16:0] mon_m;

  always #5 clock = ~clock;

  // Cycle counter used for latency and spacing checks.
  always @(posedge clock) cyc++;

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Reference CAM contents: two fixed entries, otherwise hit=key[0].
  function automatic logic [16:0] cam_model(input logic [31:0] key);
    if (key == 32'h0000_1234) return {1'b1, 16'h00AB};
    if (key == 32'h0000_5555) return {1'b0, 16'hFFFF};
    return {key[0], key[15:0] ^ 16'h0F0F};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic check_reset_outputs();
    check_output("rst_req_rdy",  32'(req_rdy),  32'd0);
    check_output("rst_rsp_vld",  32'(rsp_vld),  32'd0);
    check_output("rst_rsp_hit",  32'(rsp_hit),  32'd0);
    check_output("rst_rsp_data", 32'(rsp_data), 32'd0);
    check_output("rst_cam_en",   32'(cam_en),   32'd0);
    check_output("rst_cam_key",  cam_key,       32'd0);
    check_output("rst_busy",     32'(busy),     32'd0);
  endtask

  task automatic apply_stimulus(input int req, input logic [31:0] key);
    if (req == 0) kq0.push_back(key);
    else          kq1.push_back(key);
    exp_gnt.push_back(req);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((kq0.size() + kq1.size() + sb.size() + exp_gnt.size()) != 0 && n < budget) begin
      @(negedge clock); #1;
      n++;
    end
    check_output(tag, 32'(kq0.size() + kq1.size() + sb.size() + exp_gnt.size()), 32'd0);
  endtask

  // Monitor, scoreboard, CAM model and requester drivers, all on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      pend        = 1'b0;
      cam_exp_vld = 1'b0;
    end else begin
      if (req_rdy != '0) begin
        if (exp_gnt.size() == 0) begin
          check_output("unexpected_grant", 32'(req_rdy), 32'd0);
        end else begin
          mon_g = exp_gnt.pop_front();
          check_output("grant", 32'(req_rdy), 32'(2'b01 << mon_g));
          mon_key = (mon_g == 0) ? ((kq0.size() > 0) ? kq0[0] : 32'd0)
                                 : ((kq1.size() > 0) ? kq1[0] : 32'd0);
          mon_m    = cam_model(mon_key);
          ent.vld  = 2'(2'b01 << mon_g);
          ent.hit  = mon_m[16];
          ent.data = mon_m[16] ? mon_m[15:0] : 16'h0000;
          ent.due  = cyc + LAT + 2;
          sb.push_back(ent);
          cam_exp_vld = 1'b1;
          cam_exp_cyc = cyc + 1;
          cam_exp_key = mon_key;
          if (spacing_en && have_last) check_output("grant_spacing", 32'(cyc - last_rdy), 32'(LAT + 3));
          have_last = 1'b1;
          last_rdy  = cyc;
        end
      end
      if (cam_en) begin
        check_output("cam_en_expected", 32'(cam_exp_vld), 32'd1);
        check_output("cam_en_cycle", 32'(cyc), 32'(cam_exp_cyc));
        check_output("cam_key", cam_key, cam_exp_key);
        cam_exp_vld = 1'b0;
        pend        = 1'b1;
        pend_due    = cyc + LAT;
        pend_key    = cam_key;
      end
      if (rsp_vld != '0) begin
        if (sb.size() == 0) begin
          check_output("unexpected_rsp", 32'(rsp_vld), 32'd0);
        end else begin
          ent = sb.pop_front();
          check_output("rsp_vld",   32'(rsp_vld),  32'(ent.vld));
          check_output("rsp_hit",   32'(rsp_hit),  32'(ent.hit));
          check_output("rsp_data",  32'(rsp_data), 32'(ent.data));
          check_output("rsp_cycle", 32'(cyc),      32'(ent.due));
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        check_output("rsp_late", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
      if (req_rdy[0] && kq0.size() > 0) void'(kq0.pop_front());
      if (req_rdy[1] && kq1.size() > 0) void'(kq1.pop_front());
    end
    if (pend && cyc == pend_due) begin
      mon_m    = cam_model(pend_key);
      cam_hit  = mon_m[16];
      cam_data = mon_m[15:0];
      pend     = 1'b0;
    end else begin
      cam_hit  = 1'b1;
      cam_data = 16'hBAD0;
    end
    req_vld[0]     = (kq0.size() > 0);
    req_key[31:0]  = (kq0.size() > 0) ? kq0[0] : 32'd0;
    req_vld[1]     = (kq1.size() > 0) || pulse1;
    req_key[63:32] = (kq1.size() > 0) ? kq1[0] : (pulse1 ? pulse_key : 32'd0);
  end

  initial begin
    int n;
    reset    = 1'b0;
    req_vld  = '0;
    req_key  = '0;
    cam_hit  = 1'b0;
    cam_data = '0;
    repeat (2) @(negedge clock);
    #1;
    check_reset_outputs();
`ifdef CAM_ARB_STATS_EN
    check_output("rst_grant_cnt", grant_cnt, 32'd0);
    check_output("rst_hit_cnt", 32'(hit_cnt), 32'd0);
`endif
    reset = 1'b1;

    // Single hit lookup from requester 0.
    apply_stimulus(0, 32'h0000_1234);
    wait_drain("drain_single", 30);
    repeat (2) @(negedge clock);
    #1;
    check_output("busy_after_single", 32'(busy), 32'd0);

    // Miss from requester 1: data must be forced to zero.
    apply_stimulus(1, 32'h0000_5555);
    wait_drain("drain_miss", 30);

    // Withdrawn request: requester 1 pulses for one cycle while busy.
    apply_stimulus(0, 32'h0000_0777);
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clock); #1;
      n++;
    end
    check_output("busy_seen", 32'(busy), 32'd1);
    pulse_key = 32'h0000_9999;
    pulse1    = 1'b1;
    @(negedge clock); #1;
    pulse1    = 1'b0;
    wait_drain("drain_withdraw", 30);
    repeat (8) @(negedge clock);
    #1;
    check_output("withdraw_busy", 32'(busy), 32'd0);
    check_output("withdraw_rdy", 32'(req_rdy), 32'd0);

    // Reset during WAIT: the lookup is discarded and outputs clear at once.
    apply_stimulus(1, 32'h0000_2222);
    n = 0;
    while (!cam_en && n < 20) begin
      @(negedge clock); #1;
      n++;
    end
    check_output("cam_en_before_reset", 32'(cam_en), 32'd1);
    @(negedge clock); #1;
    sb.delete();
    kq0.delete();
    kq1.delete();
    exp_gnt.delete();
    reset = 1'b0;
    #1;
    check_reset_outputs();

    // Both requesters held from reset release: grants alternate 0,1,0,1.
    repeat (2) @(negedge clock);
    #1;
    apply_stimulus(0, 32'h0000_1234);
    apply_stimulus(1, 32'h0000_5555);
    apply_stimulus(0, 32'h0000_0003);
    apply_stimulus(1, 32'h0000_0010);
    exp_gnt.delete();
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    spacing_en = 1'b1;
    have_last  = 1'b0;
    @(negedge clock); #1;
    reset = 1'b1;
    wait_drain("drain_alternate", 80);
    spacing_en = 1'b0;

`ifdef CAM_ARB_STATS_EN
    // Statistics: three grants to requester 1, two of them hits.
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b1;
    apply_stimulus(1, 32'h0000_1234);
    apply_stimulus(1, 32'h0000_0001);
    apply_stimulus(1, 32'h0000_5555);
    wait_drain("drain_stats", 80);
    check_output("grant_cnt1", 32'(grant_cnt[31:16]), 32'd3);
    check_output("grant_cnt0", 32'(grant_cnt[15:0]), 32'd0);
    check_output("hit_cnt", 32'(hit_cnt), 32'd2);
`endif

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_lookup_arbiter.md
# cam_lookup_arbiter

Round-robin arbiter sharing one fixed-latency CAM lookup port between the dataflow search engines (busqueda_cam51, busqueda_cam) in the top_function pipeline. It accepts one lookup request at a time, drives the shared CAM, and returns the hit flag and data to the requester that issued the lookup. It sits between the search processes and the CAM storage.

## Interface
- NREQ, 2, number of requesters (2..8)
- KEY_W, 32, lookup key width
- RES_W, 16, CAM result data width
- LAT, 2, CAM read latency in cycles (1..8)

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_vld  in  NREQ  per-requester lookup request
- req_key  in  NREQ*KEY_W  key of requester i at bits [i*KEY_W +: KEY_W]
- req_rdy  out  NREQ  one-hot, one-cycle acceptance pulse
- rsp_vld  out  NREQ  one-hot, one-cycle response strobe
- rsp_hit  out  1  CAM hit for the current response
- rsp_data  out  RES_W  CAM data; 0 when rsp_hit=0
- cam_en  out  1  one-cycle CAM lookup strobe
- cam_key  out  KEY_W  latched key; valid while cam_en=1
- cam_hit  in  1  CAM hit, valid exactly LAT cycles after cam_en
- cam_data  in  RES_W  CAM data, valid together with cam_hit
- busy  out  1  high in every state except IDLE

## Operation
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if any req_vld is high, grant g is the first requester with req_vld=1, searching upward from ptr with wrap at NREQ-1.
  - Pulse req_rdy[g], latch req_key[g] and g, then go to ISSUE.
  - If no req_vld is high, stay in IDLE.
- ISSUE: cam_en=1 for one cycle, cam_key=latched key. Load wait counter with LAT-1, then go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0, sample cam_hit/cam_data into registers and go to RESP.
- RESP: rsp_vld[g]=1 for one cycle, rsp_hit=registered hit, rsp_data=hit ? registered data : 0. Set ptr=(g+1) mod NREQ and go to IDLE.
- Requester rules:
  - A requester holds req_vld and req_key stable until it sees req_rdy.
  - Dropping req_vld before a grant is legal and withdraws the request.
  - req_vld that stays high after req_rdy is treated as a new request.
- Only one lookup is outstanding. Requests are never queued internally.
- Reset at any point:
  - FSM goes to IDLE and ptr=0.
  - An in-flight lookup is discarded and no rsp_vld is issued for it.
  - Statistics counters clear.
- Reset values: all outputs 0 (req_rdy, rsp_vld, rsp_hit, rsp_data, cam_en, cam_key, busy, stats).

## Timing
- Request accepted at cycle T (req_rdy high):
  - cam_en at T+1.
  - CAM result sampled at T+1+LAT.
  - rsp_vld at T+LAT+2.
  - FSM back in IDLE at T+LAT+3.
- Earliest next req_rdy: T+LAT+3. Maximum throughput is one lookup per LAT+3 cycles.
- Requests that arrive in ISSUE, WAIT or RESP are held by the requester and considered in the next IDLE cycle.
- All outputs are registered. There is no combinational path from req_vld or cam_* to any output.

## Configuration
- CAM_ARB_STATS_EN defined:
  - Adds output grant_cnt (NREQ*16): per-requester accepted lookups, incremented on each req_rdy.
  - Adds output hit_cnt (16): number of RESP cycles with rsp_hit=1.
  - All counters saturate at 16'hFFFF and clear on reset.
- CAM_ARB_STATS_EN undefined: these ports and counters are absent, and arbitration behaviour is identical.

## Test plan
- Single lookup, LAT=2, NREQ=2: req_vld[0]=1 with key 0x1234 at cycle 0, cam returns hit=1, data=0x00AB. Required: req_rdy[0] at 0, cam_en with cam_key=0x1234 at 1, rsp_vld=2'b01 with rsp_hit=1 and rsp_data=0x00AB at 4.
- Simultaneous requests: req_vld=2'b11 held from reset release. Required: grants alternate 0,1,0,1, one every 5 cycles; each rsp_vld matches its grant index.
- Miss: cam_hit=0 with cam_data=0xFFFF. Required: rsp_hit=0 and rsp_data=0x0000.
- Withdrawn request: req_vld[1] pulses high for one cycle while busy=1. Required: no req_rdy[1] is ever issued for it and the FSM returns to IDLE with no further grant.
- Reset mid-lookup: reset asserted during WAIT. Required: no rsp_vld, all outputs 0 immediately, and the first grant after release goes to requester 0.
- Statistics (CAM_ARB_STATS_EN): 3 grants to requester 1 with 2 hits. Required: grant_cnt[1]=3, grant_cnt[0]=0, hit_cnt=2.
